// File: rtl/bbox_raster_scan.sv
// -----------------------------------------------------------------------------
// bbox_raster_scan
//   Triangle setup and pixel walker. Accepts one triangle (three signed
//   fixed-point vertices) per tri_valid/tri_ready handshake. It computes the
//   vertex bounding box rounded to integer pixels, and optionally clips the box
//   to the screen. It then streams every pixel coordinate inside the box in
//   row-major order over a px_valid/px_ready interface.
//
//   Optional feature macro: BBOX_SCREEN_CLIP_EN
//     defined     : box clipped to [0,SCREEN_W-1] x [0,SCREEN_H-1]; a box that
//                   lies wholly off screen becomes empty.
//     not defined : no clipping; coordinates are emitted as signed values.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   tri_valid / tri_ready       triangle handshake (ready only while idle)
//   v0x..v2x, v0y..v2y   [W]    vertex coordinates, signed fixed point
//   bb_xmin..bb_ymax     [PW]   registered rounded (and clipped) box bounds
//   px_valid / px_ready         pixel stream handshake
//   px_x, px_y           [PW]   current pixel coordinate, signed
//   px_last                     current pixel is the last one of the box
//   tri_done                    one-cycle pulse: triangle finished (or empty)
//
// Timing
//   Accept at edge N registers the vertex min/max. Edge N+1 registers the
//   rounded and clipped bounds. Edge N+2 loads bb_* and the first pixel, or
//   pulses tri_done for an empty box. After that the walker runs at one pixel
//   per clock while px_ready is high.
// -----------------------------------------------------------------------------
module bbox_raster_scan #(
  parameter  int W        = 16,
  parameter  int FRAC     = 6,
  parameter  int SCREEN_W = 640,
  parameter  int SCREEN_H = 480,
  localparam int PW       = W - FRAC + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic signed [W-1:0]  v0x,
  input  logic signed [W-1:0]  v1x,
  input  logic signed [W-1:0]  v2x,
  input  logic signed [W-1:0]  v0y,
  input  logic signed [W-1:0]  v1y,
  input  logic signed [W-1:0]  v2y,
  output logic signed [PW-1:0] bb_xmin,
  output logic signed [PW-1:0] bb_xmax,
  output logic signed [PW-1:0] bb_ymin,
  output logic signed [PW-1:0] bb_ymax,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic signed [PW-1:0] px_x,
  output logic signed [PW-1:0] px_y,
  output logic                 px_last,
  output logic                 tri_done
);

  // Reject parameter sets where the fixed-point split or the screen size makes no sense.
  if (FRAC < 1 || FRAC >= W || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
    $error("bbox_raster_scan: unsupported parameter set");
  end

  // ROUND is the internal cycle between accept and CALC. It holds the
  // rounding and clipping stage, which gives the two-edge accept-to-output latency.
  typedef enum logic [1:0] {IDLE, ROUND, CALC, SCAN} state_t;

  localparam logic signed [W:0] HALF = (W+1)'(2 ** (FRAC - 1));

  state_t               state;
  logic signed [W-1:0]  mn_x, mx_x, mn_y, mx_y;   // raw fixed-point extremes
  logic signed [PW-1:0] r_xmin, r_xmax, r_ymin, r_ymax; // rounded + clipped
  logic signed [PW-1:0] rx_min, rx_max, ry_min, ry_max; // rounded (comb)
  logic signed [PW-1:0] c_xmin, c_xmax, c_ymin, c_ymax; // clipped (comb)
  logic signed [PW-1:0] nx, ny;
  logic                 nlast;

  function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Round to nearest with ties toward +inf. The sum is taken one bit wider so
  // that the largest positive vertex cannot wrap. An arithmetic shift gives a
  // floor for negative values.
  function automatic logic signed [PW-1:0] round_fx(input logic signed [W-1:0] v);
    logic signed [W:0] s;
    s = {v[W-1], v} + HALF;
    return PW'(s >>> FRAC);
  endfunction

  assign rx_min = round_fx(mn_x);
  assign rx_max = round_fx(mx_x);
  assign ry_min = round_fx(mn_y);
  assign ry_max = round_fx(mx_y);

`ifdef BBOX_SCREEN_CLIP_EN
  localparam logic signed [PW-1:0] X_LIM = PW'(SCREEN_W - 1);
  localparam logic signed [PW-1:0] Y_LIM = PW'(SCREEN_H - 1);

  // A box that lies wholly off screen ends up with min > max and is treated as empty.
  assign c_xmin = (rx_min < 0)     ? '0    : rx_min;
  assign c_xmax = (rx_max > X_LIM) ? X_LIM : rx_max;
  assign c_ymin = (ry_min < 0)     ? '0    : ry_min;
  assign c_ymax = (ry_max > Y_LIM) ? Y_LIM : ry_max;
`else
  assign c_xmin = rx_min;
  assign c_xmax = rx_max;
  assign c_ymin = ry_min;
  assign c_ymax = ry_max;
`endif

  // Next pixel in row-major order, and whether that pixel closes the box.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (latch).
    nx = px_x + PW'(1);
    ny = px_y;
    if (!(px_x < bb_xmax)) begin
      nx = bb_xmin;
      ny = px_y + PW'(1);
    end
  end

  assign nlast = (nx == bb_xmax) && (ny == bb_ymax);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tri_ready <= 1'b1;
      tri_done  <= 1'b0;
      px_valid  <= 1'b0;
      px_last   <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      bb_xmin   <= '0;
      bb_xmax   <= '0;
      bb_ymin   <= '0;
      bb_ymax   <= '0;
      mn_x      <= '0;
      mx_x      <= '0;
      mn_y      <= '0;
      mx_y      <= '0;
      r_xmin    <= '0;
      r_xmax    <= '0;
      r_ymin    <= '0;
      r_ymax    <= '0;
    end else begin
      tri_done <= 1'b0;  // pulse; re-asserted only on the finishing cycle
      unique case (state)
        IDLE: begin
          if (tri_valid) begin
            mn_x      <= min3(v0x, v1x, v2x);
            mx_x      <= max3(v0x, v1x, v2x);
            mn_y      <= min3(v0y, v1y, v2y);
            mx_y      <= max3(v0y, v1y, v2y);
            tri_ready <= 1'b0;
            state     <= ROUND;
          end
        end
        ROUND: begin
          r_xmin <= c_xmin;
          r_xmax <= c_xmax;
          r_ymin <= c_ymin;
          r_ymax <= c_ymax;
          state  <= CALC;
        end
        CALC: begin
          bb_xmin <= r_xmin;
          bb_xmax <= r_xmax;
          bb_ymin <= r_ymin;
          bb_ymax <= r_ymax;
          px_x    <= r_xmin;
          px_y    <= r_ymin;
          if ((r_xmin > r_xmax) || (r_ymin > r_ymax)) begin
            tri_done  <= 1'b1;
            tri_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            px_valid <= 1'b1;
            px_last  <= (r_xmin == r_xmax) && (r_ymin == r_ymax);
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (px_ready) begin
            if (px_last) begin
              px_valid  <= 1'b0;
              px_last   <= 1'b0;
              tri_done  <= 1'b1;
              tri_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              px_x    <= nx;
              px_y    <= ny;
              px_last <= nlast;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_raster_scan.sv
// -----------------------------------------------------------------------------
// tb_bbox_raster_scan
//   Directed bench for bbox_raster_scan with its default parameters. For each
//   triangle sent, a reference model (integer floor rounding, optional clip)
//   pushes the expected pixel stream into a queue. The drain loop pops one
//   entry per pixel handshake. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bbox_raster_scan;

  localparam int W  = 16;
  localparam int PW = 11;

  typedef struct {
    int x;
    int y;
    bit last;
  } px_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tri_valid = 1'b0;
  logic px_ready = 1'b0;
  logic signed [W-1:0] v0x = '0, v1x = '0, v2x = '0;
  logic signed [W-1:0] v0y = '0, v1y = '0, v2y = '0;
  logic tri_ready, px_valid, px_last, tri_done;
  logic signed [PW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax, px_x, px_y;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  ex_xmin, ex_xmax, ex_ymin, ex_ymax;
  px_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bbox_raster_scan dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v0x(v0x), .v1x(v1x), .v2x(v2x),
    .v0y(v0y), .v1y(v1y), .v2y(v2y),
    .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_last(px_last),
    .tri_done(tri_done)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // floor((v + 32) / 64) using plain integer arithmetic
  function automatic int rnd(input int v);
    int t;
    t = v + 32;
    return (t >= 0) ? t / 64 : -((-t + 63) / 64);
  endfunction

  function automatic int clip_lo(input int v);
`ifdef BBOX_SCREEN_CLIP_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int clip_hi(input int v, input int lim);
`ifdef BBOX_SCREEN_CLIP_EN
    return (v > lim) ? lim : v;
`else
    return (lim > 0) ? v : v;
`endif
  endfunction

  function automatic int mn3(input int a, b, c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int mx3(input int a, b, c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  task automatic check_bb(input string tag);
    check({tag, "_bb_xmin"}, bb_xmin, ex_xmin);
    check({tag, "_bb_xmax"}, bb_xmax, ex_xmax);
    check({tag, "_bb_ymin"}, bb_ymin, ex_ymin);
    check({tag, "_bb_ymax"}, bb_ymax, ex_ymax);
  endtask

  // Call this at a falling edge. It returns at the falling edge that follows the accept edge.
  task automatic send(input int x0, x1, x2, y0, y1, y2, input bit hold);
    int t;
    px_t p;
    ex_xmin = clip_lo(rnd(mn3(x0, x1, x2)));
    ex_xmax = clip_hi(rnd(mx3(x0, x1, x2)), 639);
    ex_ymin = clip_lo(rnd(mn3(y0, y1, y2)));
    ex_ymax = clip_hi(rnd(mx3(y0, y1, y2)), 479);
    for (int y = ex_ymin; y <= ex_ymax; y++)
      for (int x = ex_xmin; x <= ex_xmax; x++) begin
        p.x = x;
        p.y = y;
        p.last = (x == ex_xmax) && (y == ex_ymax);
        exp_q.push_back(p);
      end
    v0x = 16'(x0); v1x = 16'(x1); v2x = 16'(x2);
    v0y = 16'(y0); v1y = 16'(y1); v2y = 16'(y2);
    tri_valid = 1'b1;
    t = 0;
    while (!tri_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tri_ready) check("accept_timeout", tri_ready, 1);
    @(negedge clk);
    acc_cyc = cyc;
    tri_valid = hold;
  endtask

  // Consume pixels until tri_done. This holds px_ready low for slen cycles while
  // pixel (sx,sy) is offered. With stop_after >= 0 it returns after that many handshakes.
  task automatic drain(input int sx, sy, slen, stop_after, input string tag);
    int  popped = 0;
    int  stalled = 0;
    bit  seen = 1'b0;
    px_t e;
    for (int t = 0; t < 400; t++) begin
      if (stop_after >= 0 && popped == stop_after) begin
        px_ready = 1'b0;
        return;
      end
      if (px_valid && !seen) begin
        seen = 1'b1;
        check({tag, "_first_px_latency"}, cyc - acc_cyc, 2);
        check_bb(tag);
      end
      if (px_valid) check({tag, "_ready_busy"}, tri_ready, 0);
      if (tri_done) begin
        check({tag, "_done_queue_left"}, exp_q.size(), 0);
        check({tag, "_done_px_valid"}, px_valid, 0);
        if (!seen) begin
          check({tag, "_empty_done_latency"}, cyc - acc_cyc, 2);
          check_bb(tag);
        end
        px_ready = 1'b0;
        if (!tri_valid) begin
          @(negedge clk);
          check({tag, "_done_pulse_width"}, tri_done, 0);
          check({tag, "_idle_ready"}, tri_ready, 1);
        end
        return;
      end
      if (px_valid && px_x == sx && px_y == sy && stalled < slen) begin
        px_ready = 1'b0;
        stalled++;
        if (exp_q.size() > 0) begin
          check({tag, "_stall_x"}, px_x, exp_q[0].x);
          check({tag, "_stall_y"}, px_y, exp_q[0].y);
          check({tag, "_stall_last"}, px_last, exp_q[0].last);
        end
      end else begin
        px_ready = 1'b1;
      end
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_pixel"}, exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_px_x"}, px_x, e.x);
          check({tag, "_px_y"}, px_y, e.y);
          check({tag, "_px_last"}, px_last, e.last);
        end
        popped++;
      end
      @(negedge clk);
    end
    check({tag, "_scan_timeout"}, tri_done, 1);
    px_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int sv_xmin, sv_xmax, sv_ymin, sv_ymax;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tri_ready", tri_ready, 1);
    check("rst_px_valid", px_valid, 0);
    check("rst_tri_done", tri_done, 0);
    check("rst_px_x", px_x, 0);
    check("rst_bb_xmax", bb_xmax, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic 3x2 box
    send(64, 192, 64, 64, 64, 128, 1'b0);
    drain(-999, -999, 0, -1, "t1");

    // 2: rounding boundaries in x and y, including the largest positive vertex
    send(95, 95, 95, 96, 96, 96, 1'b0);
    drain(-999, -999, 0, -1, "t2a");
    send(96, 96, 96, -33, -33, -33, 1'b0);
    drain(-999, -999, 0, -1, "t2b");
    send(-32, -32, -32, 95, 95, 95, 1'b0);
    drain(-999, -999, 0, -1, "t2c");
    send(-33, -33, -33, -32, -32, -32, 1'b0);
    drain(-999, -999, 0, -1, "t2d");
    send(32767, 32767, 32767, 64, 64, 64, 1'b0);
    drain(-999, -999, 0, -1, "t2e");
    send(64, 64, 64, 32767, 32767, 32767, 1'b0);
    drain(-999, -999, 0, -1, "t2f");

    // 3: downstream stall of 3 cycles on pixel (2,1)
    send(64, 192, 64, 64, 64, 128, 1'b0);
    drain(2, 1, 3, -1, "t3");

    // 4: vertices at x = -10.0 (empty when clipped, single pixel otherwise)
    send(-640, -640, -640, 64, 64, 64, 1'b0);
    drain(-999, -999, 0, -1, "t4");

    // 5: reset while the third pixel is on offer
    send(64, 192, 64, 64, 64, 128, 1'b0);
    drain(-999, -999, 0, 2, "t5pre");
    check("t5_pre_reset_px_x", px_x, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_px_valid", px_valid, 0);
    check("t5_rst_tri_done", tri_done, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_rst_ready", tri_ready, 1);
    send(128, 256, 128, 192, 192, 192, 1'b0);
    drain(-999, -999, 0, -1, "t5");

    // 6: tri_valid held high through a scan. The inputs switch to triangle B right after A is accepted.
    send(64, 192, 64, 64, 64, 128, 1'b1);
    v0x = 16'sd0;  v1x = 16'sd128; v2x = 16'sd0;
    v0y = 16'sd0;  v1y = 16'sd0;   v2y = 16'sd64;
    drain(-999, -999, 0, -1, "t6a");
    sv_xmin = ex_xmin; sv_xmax = ex_xmax; sv_ymin = ex_ymin; sv_ymax = ex_ymax;
    send(0, 128, 0, 0, 0, 64, 1'b0);
    check("t6_bb_hold_xmin", bb_xmin, sv_xmin);
    check("t6_bb_hold_xmax", bb_xmax, sv_xmax);
    check("t6_bb_hold_ymin", bb_ymin, sv_ymin);
    check("t6_bb_hold_ymax", bb_ymax, sv_ymax);
    drain(-999, -999, 0, -1, "t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
